image_paste: RTL and testbench

Re-inserts a cropped pixel stream into a full display raster: accepts window-only pixels (vs_i/de_i/rgb_i, raster order, as produced by the crop stage), buffers them in an internal FIFO, and drives a free-running full-frame timing (hs/vs/de/rgb) in which the window rectangle is filled from the FIFO and everything else is background colour. It sits between the processing chain and the display encoder, on the same single pixel clock.

---
 rtl/image_paste.sv | 128 ++++++++++++
 tb/tb_image_paste.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_paste.sv
// Pastes a cropped window pixel stream back into a free-running full raster via a pixel FIFO.
// Optional 1-pixel border ring around the window: define IMAGE_PASTE_BORDER_EN.
module image_paste #(
  parameter int          H_DISP       = 1920,
  parameter int          H_FP         = 88,
  parameter int          H_SYNC       = 44,
  parameter int          H_TOTAL      = 2200,
  parameter int          V_DISP       = 1080,
  parameter int          V_FP         = 4,
  parameter int          V_SYNC       = 5,
  parameter int          V_TOTAL      = 1125,
  parameter int          FIFO_DEPTH   = 2048,
  parameter logic [23:0] BG_COLOR     = 24'h000000,
  parameter logic [23:0] BORDER_COLOR = 24'hFF0000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [10:0]                     start_x,
  input  logic [10:0]                     start_y,
  input  logic [10:0]                     end_x,
  input  logic [10:0]                     end_y,
  input  logic                            vs_i,
  input  logic                            de_i,
  input  logic [23:0]                     rgb_i,
  output logic                            hs_o,
  output logic                            vs_o,
  output logic                            de_o,
  output logic [23:0]                     rgb_o,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            underflow,
  output logic                            overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [11:0]   h_cnt, v_cnt;
  logic [10:0]   sx_q, sy_q, ex_q, ey_q;
  logic [10:0]   sx, sy, ex, ey;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [23:0]   mem [FIFO_DEPTH];

  logic frame_start, active, hs, vs, in_win, full, empty, rd, wr, border;

  // At the first pixel of a frame the freshly sampled window is used directly,
  // so that pixel already sees the same window the registers hold for the rest of the frame.
  always_comb begin
    frame_start = (h_cnt == '0) && (v_cnt == '0);
    sx = frame_start ? start_x : sx_q;
    sy = frame_start ? start_y : sy_q;
    ex = frame_start ? end_x   : ex_q;
    ey = frame_start ? end_y   : ey_q;
    active = (h_cnt < 12'(H_DISP)) && (v_cnt < 12'(V_DISP));
    hs     = (h_cnt >= 12'(H_DISP + H_FP)) && (h_cnt < 12'(H_DISP + H_FP + H_SYNC));
    vs     = (v_cnt >= 12'(V_DISP + V_FP)) && (v_cnt < 12'(V_DISP + V_FP + V_SYNC));
    in_win = active && (h_cnt >= {1'b0, sx}) && (h_cnt < {1'b0, ex})
                    && (v_cnt >= {1'b0, sy}) && (v_cnt < {1'b0, ey});
    full   = (fifo_level == LW'(FIFO_DEPTH));
    empty  = (fifo_level == '0);
    rd     = in_win && !empty && !vs_i;
    wr     = de_i && !vs_i && (!full || rd);
  end

`ifdef IMAGE_PASTE_BORDER_EN
  logic col_ring, row_ring;
  // Comparisons are shifted by +1 so a window touching row/column 0 has no wrapped ring.
  always_comb begin
    col_ring = ((h_cnt + 12'd1 == {1'b0, sx}) || (h_cnt == {1'b0, ex}))
               && (v_cnt + 12'd1 >= {1'b0, sy}) && (v_cnt <= {1'b0, ey});
    row_ring = ((v_cnt + 12'd1 == {1'b0, sy}) || (v_cnt == {1'b0, ey}))
               && (h_cnt + 12'd1 >= {1'b0, sx}) && (h_cnt <= {1'b0, ex});
    border   = active && (sx < ex) && (sy < ey) && !in_win && (col_ring || row_ring);
  end
`else
  always_comb border = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= rgb_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      sx_q       <= start_x;
      sy_q       <= start_y;
      ex_q       <= end_x;
      ey_q       <= end_y;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      underflow  <= 1'b0;
      overflow   <= 1'b0;
      hs_o       <= 1'b0;
      vs_o       <= 1'b0;
      de_o       <= 1'b0;
      rgb_o      <= '0;
    end else begin
      if (h_cnt == 12'(H_TOTAL - 1)) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == 12'(V_TOTAL - 1)) ? '0 : v_cnt + 12'd1;
      end else begin
        h_cnt <= h_cnt + 12'd1;
      end
      if (frame_start) begin
        sx_q <= start_x;
        sy_q <= start_y;
        ex_q <= end_x;
        ey_q <= end_y;
      end
      if (vs_i) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_level <= '0;
      end else begin
        if (wr) wr_ptr <= wr_ptr + AW'(1);
        if (rd) rd_ptr <= rd_ptr + AW'(1);
        fifo_level <= fifo_level + LW'(wr) - LW'(rd);
      end
      if (in_win && empty) underflow <= 1'b1;
      if (de_i && !vs_i && full && !rd) overflow <= 1'b1;
      hs_o  <= hs;
      vs_o  <= vs;
      de_o  <= active;
      rgb_o <= rd ? mem[rd_ptr] : border ? BORDER_COLOR : active ? BG_COLOR : '0;
    end
  end
endmodule

// File: tb/tb_image_paste.sv
// Directed self-checking bench for image_paste on a 16x10 raster (8x6 active, 16-entry FIFO).
module tb_image_paste;
  localparam logic [23:0] BG = 24'h101010;
  localparam logic [23:0] BD = 24'hFF0000;
`ifdef IMAGE_PASTE_BORDER_EN
  localparam logic [23:0] RING = BD;
`else
  localparam logic [23:0] RING = BG;
`endif
  localparam int FRAME = 160;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] start_x, start_y, end_x, end_y;
  logic        vs_i, de_i;
  logic [23:0] rgb_i;
  logic        hs_o, vs_o, de_o;
  logic [23:0] rgb_o;
  logic [4:0]  fifo_level;
  logic        underflow, overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [23:0] c_rgb [10][16];
  logic        c_hs  [10][16];
  logic        c_vs  [10][16];
  logic        c_de  [10][16];
  logic        c_uf  [10][16];
  logic [4:0]  c_lvl [10][16];

  image_paste #(
    .H_DISP(8), .H_FP(2), .H_SYNC(2), .H_TOTAL(16),
    .V_DISP(6), .V_FP(1), .V_SYNC(1), .V_TOTAL(10),
    .FIFO_DEPTH(16), .BG_COLOR(BG), .BORDER_COLOR(BD)
  ) dut (
    .clk(clk), .rst(rst),
    .start_x(start_x), .start_y(start_y), .end_x(end_x), .end_y(end_y),
    .vs_i(vs_i), .de_i(de_i), .rgb_i(rgb_i),
    .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o), .rgb_o(rgb_o),
    .fifo_level(fifo_level), .underflow(underflow), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // After tick number n (counted from reset release) the outputs show pixel n-1.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic record();
    int p, h, v;
    p = cyc - 1;
    h = p % 16;
    v = (p / 16) % 10;
    c_rgb[v][h] = rgb_o;
    c_hs[v][h]  = hs_o;
    c_vs[v][h]  = vs_o;
    c_de[v][h]  = de_o;
    c_uf[v][h]  = underflow;
    c_lvl[v][h] = fifo_level;
  endtask

  task automatic capture_frame();
    for (int i = 0; i < FRAME; i++) begin
      tick();
      record();
    end
  endtask

  task automatic wait_frame_start();
    for (int i = 0; i < FRAME && (cyc % FRAME) != 0; i++) tick();
  endtask

  task automatic set_win(input int sx, input int sy, input int ex, input int ey);
    start_x = 11'(sx); start_y = 11'(sy); end_x = 11'(ex); end_y = 11'(ey);
  endtask

  task automatic do_reset();
    rst = 1'b1; de_i = 1'b0; vs_i = 1'b0; rgb_i = '0;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic push(input logic [23:0] d);
    de_i = 1'b1;
    rgb_i = d;
    tick();
    de_i = 1'b0;
  endtask

  task automatic test_reset();
    set_win(0, 0, 0, 0);
    rst = 1'b1; de_i = 1'b1; vs_i = 1'b0; rgb_i = 24'hABCDEF;
    tick();
    tick();
    checks++; if (hs_o !== 1'b0) begin errors++; $display("FAIL reset_hs: got %b exp 0", hs_o); end
    checks++; if (vs_o !== 1'b0) begin errors++; $display("FAIL reset_vs: got %b exp 0", vs_o); end
    checks++; if (de_o !== 1'b0) begin errors++; $display("FAIL reset_de: got %b exp 0", de_o); end
    checks++; if (rgb_o !== 24'h0) begin errors++; $display("FAIL reset_rgb: got %h exp 000000", rgb_o); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d exp 0", fifo_level); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b exp 0", underflow); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b exp 0", overflow); end
    de_i = 1'b0;
    rst = 1'b0;
    cyc = 0;
    tick();
    checks++; if (de_o !== 1'b1 || hs_o !== 1'b0 || rgb_o !== BG)
      begin errors++; $display("FAIL first_pixel: got de=%b hs=%b rgb=%h exp de=1 hs=0 rgb=%h", de_o, hs_o, rgb_o, BG); end
    for (int i = 0; i < 40; i++) tick();
    push(24'h1); push(24'h2); push(24'h3);
    checks++; if (fifo_level !== 5'd3) begin errors++; $display("FAIL midframe_level: got %0d exp 3", fifo_level); end
    rst = 1'b1;
    tick();
    checks++; if (fifo_level !== 5'd0 || de_o !== 1'b0)
      begin errors++; $display("FAIL midframe_reset: got level=%0d de=%b exp level=0 de=0", fifo_level, de_o); end
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 11; i++) tick();
    checks++; if (hs_o !== 1'b1) begin errors++; $display("FAIL restart_hs_at_h10: got %b exp 1", hs_o); end
  endtask

  task automatic test_timing();
    int bad, n_hs, n_vs, n_de;
    logic e_de, e_hs, e_vs;
    logic [23:0] e_rgb;
    set_win(0, 0, 0, 0);
    do_reset();
    capture_frame();
    bad = 0; n_hs = 0; n_vs = 0; n_de = 0;
    for (int v = 0; v < 10; v++) begin
      for (int h = 0; h < 16; h++) begin
        e_de  = (h < 8) && (v < 6);
        e_hs  = (h == 10) || (h == 11);
        e_vs  = (v == 7);
        e_rgb = e_de ? BG : 24'h0;
        if (c_de[v][h] !== e_de || c_hs[v][h] !== e_hs || c_vs[v][h] !== e_vs || c_rgb[v][h] !== e_rgb) bad++;
        n_hs += int'(c_hs[v][h] === 1'b1);
        n_vs += int'(c_vs[v][h] === 1'b1);
        n_de += int'(c_de[v][h] === 1'b1);
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL timing_pixels: got %0d bad pixels exp 0", bad); end
    checks++; if (n_hs !== 20) begin errors++; $display("FAIL timing_hs_count: got %0d exp 20", n_hs); end
    checks++; if (n_vs !== 16) begin errors++; $display("FAIL timing_vs_count: got %0d exp 16", n_vs); end
    checks++; if (n_de !== 48) begin errors++; $display("FAIL timing_de_count: got %0d exp 48", n_de); end
    checks++; if (c_hs[0][10] !== 1'b1 || c_hs[0][12] !== 1'b0 || c_hs[0][9] !== 1'b0)
      begin errors++; $display("FAIL timing_hs_edges: got h9=%b h10=%b h12=%b exp 0 1 0", c_hs[0][9], c_hs[0][10], c_hs[0][12]); end
    checks++; if (c_vs[7][0] !== 1'b1 || c_vs[6][15] !== 1'b0 || c_vs[8][0] !== 1'b0)
      begin errors++; $display("FAIL timing_vs_edges: got v6=%b v7=%b v8=%b exp 0 1 0", c_vs[6][15], c_vs[7][0], c_vs[8][0]); end
    checks++; if (underflow !== 1'b0 || overflow !== 1'b0)
      begin errors++; $display("FAIL timing_flags: got uf=%b of=%b exp 0 0", underflow, overflow); end
  endtask

  task automatic test_paste();
    int bad, k;
    logic [23:0] e;
    set_win(0, 0, 0, 0);
    do_reset();
    for (int i = 1; i <= 8; i++) push(24'(i));
    checks++; if (fifo_level !== 5'd8) begin errors++; $display("FAIL paste_preload_level: got %0d exp 8", fifo_level); end
    set_win(2, 1, 6, 3);
    wait_frame_start();
    capture_frame();
    bad = 0; k = 1;
    for (int v = 0; v < 10; v++) begin
      for (int h = 0; h < 16; h++) begin
        if (h >= 2 && h < 6 && v >= 1 && v < 3) begin e = 24'(k); k++; end
        else if (((h == 1 || h == 6) && v <= 3) || ((v == 0 || v == 3) && h >= 1 && h <= 6)) e = RING;
        else if (h < 8 && v < 6) e = BG;
        else e = 24'h0;
        if (c_rgb[v][h] !== e) bad++;
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL paste_frame: got %0d bad pixels exp 0", bad); end
    checks++; if (c_rgb[1][2] !== 24'h1 || c_rgb[2][5] !== 24'h8)
      begin errors++; $display("FAIL paste_corners: got %h %h exp 000001 000008", c_rgb[1][2], c_rgb[2][5]); end
    checks++; if (c_rgb[1][1] !== RING || c_rgb[1][7] !== BG)
      begin errors++; $display("FAIL paste_outside: got %h %h exp %h %h", c_rgb[1][1], c_rgb[1][7], RING, BG); end
    checks++; if (c_lvl[1][5] !== 5'd4 || c_lvl[2][5] !== 5'd0)
      begin errors++; $display("FAIL paste_level: got %0d %0d exp 4 0", c_lvl[1][5], c_lvl[2][5]); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL paste_underflow: got %b exp 0", underflow); end
  endtask

  task automatic test_underflow();
    set_win(0, 0, 0, 0);
    do_reset();
    for (int i = 1; i <= 5; i++) push(24'(i));
    set_win(2, 1, 6, 3);
    wait_frame_start();
    capture_frame();
    checks++; if (c_rgb[2][2] !== 24'h5) begin errors++; $display("FAIL uf_last_pixel: got %h exp 000005", c_rgb[2][2]); end
    checks++; if (c_rgb[2][3] !== BG || c_rgb[2][5] !== BG)
      begin errors++; $display("FAIL uf_fill: got %h %h exp %h", c_rgb[2][3], c_rgb[2][5], BG); end
    checks++; if (c_uf[2][2] !== 1'b0 || c_uf[2][3] !== 1'b1)
      begin errors++; $display("FAIL uf_onset: got %b %b exp 0 1", c_uf[2][2], c_uf[2][3]); end
    set_win(0, 0, 0, 0);
    capture_frame();
    vs_i = 1'b1;
    tick();
    vs_i = 1'b0;
    tick();
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b exp 1", underflow); end
  endtask

  task automatic test_overflow();
    set_win(0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 16; i++) push(24'h100 + 24'(i));
    checks++; if (fifo_level !== 5'd16 || overflow !== 1'b0)
      begin errors++; $display("FAIL of_full: got level=%0d of=%b exp 16 0", fifo_level, overflow); end
    push(24'h110);
    checks++; if (fifo_level !== 5'd16 || overflow !== 1'b1)
      begin errors++; $display("FAIL of_drop: got level=%0d of=%b exp 16 1", fifo_level, overflow); end
    set_win(0, 0, 8, 2);
    wait_frame_start();
    capture_frame();
    checks++; if (c_rgb[0][0] !== 24'h100 || c_rgb[1][7] !== 24'h10F)
      begin errors++; $display("FAIL of_contents: got %h %h exp 000100 00010f", c_rgb[0][0], c_rgb[1][7]); end
    checks++; if (c_lvl[1][7] !== 5'd0 || c_uf[1][7] !== 1'b0 || overflow !== 1'b1)
      begin errors++; $display("FAIL of_drain: got level=%0d uf=%b of=%b exp 0 0 1", c_lvl[1][7], c_uf[1][7], overflow); end
  endtask

  task automatic test_flush();
    set_win(0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 10; i++) push(24'h200 + 24'(i));
    checks++; if (fifo_level !== 5'd10) begin errors++; $display("FAIL flush_pre: got %0d exp 10", fifo_level); end
    vs_i = 1'b1; de_i = 1'b1; rgb_i = 24'h55;
    tick();
    vs_i = 1'b0; de_i = 1'b0;
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL flush_level: got %0d exp 0", fifo_level); end
    set_win(2, 1, 6, 3);
    wait_frame_start();
    capture_frame();
    checks++; if (c_rgb[1][2] !== BG || c_uf[1][2] !== 1'b1)
      begin errors++; $display("FAIL flush_window: got rgb=%h uf=%b exp %h 1", c_rgb[1][2], c_uf[1][2], BG); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_overflow: got %b exp 0", overflow); end
  endtask

  task automatic test_window_change();
    set_win(0, 0, 0, 0);
    do_reset();
    for (int i = 1; i <= 8; i++) push(24'h10 + 24'(i));
    set_win(2, 1, 6, 3);
    wait_frame_start();
    for (int i = 0; i < FRAME; i++) begin
      tick();
      record();
      if (i == 20) start_x = 11'd4;
      if (i >= 100 && i < 104) begin de_i = 1'b1; rgb_i = 24'h21 + 24'(i - 100); end
      else de_i = 1'b0;
    end
    checks++; if (c_rgb[1][2] !== 24'h11 || c_rgb[2][2] !== 24'h15 || c_rgb[2][5] !== 24'h18)
      begin errors++; $display("FAIL wc_old_window: got %h %h %h exp 000011 000015 000018", c_rgb[1][2], c_rgb[2][2], c_rgb[2][5]); end
    checks++; if (c_rgb[1][1] !== RING || c_rgb[0][2] !== RING || c_rgb[3][6] !== RING || c_rgb[0][0] !== BG)
      begin errors++; $display("FAIL wc_ring_old: got %h %h %h %h exp %h x3 then %h", c_rgb[1][1], c_rgb[0][2], c_rgb[3][6], c_rgb[0][0], RING, BG); end
    capture_frame();
    checks++; if (c_rgb[1][4] !== 24'h21 || c_rgb[2][5] !== 24'h24)
      begin errors++; $display("FAIL wc_new_window: got %h %h exp 000021 000024", c_rgb[1][4], c_rgb[2][5]); end
    checks++; if (c_rgb[1][2] !== BG || c_rgb[1][3] !== RING)
      begin errors++; $display("FAIL wc_new_ring: got %h %h exp %h %h", c_rgb[1][2], c_rgb[1][3], BG, RING); end
    checks++; if (underflow !== 1'b0 || fifo_level !== 5'd0)
      begin errors++; $display("FAIL wc_flags: got uf=%b level=%0d exp 0 0", underflow, fifo_level); end
  endtask

  initial begin
    rst = 1'b1; vs_i = 1'b0; de_i = 1'b0; rgb_i = '0;
    set_win(0, 0, 0, 0);
    test_reset();
    test_timing();
    test_paste();
    test_underflow();
    test_overflow();
    test_flush();
    test_window_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
